// File: rtl/alu_seq_pkg.sv
// Shared types for the multi-cycle ALU: opcodes, FSM states and the flag word.
package definitions;

    typedef enum logic [3:0] {
        ADD  = 4'd0,
        ADDC = 4'd1,
        SUB  = 4'd2,
        SUBC = 4'd3,
        LSL  = 4'd4,
        LSLC = 4'd5,
        LSR  = 4'd6,
        LSRC = 4'd7,
        ASR  = 4'd8,
        NOT  = 4'd9,
        AND  = 4'd10,
        OR   = 4'd11,
        CMP  = 4'd12,
        MUL  = 4'd13
    } alu_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_DONE = 2'd2
    } alu_state_e;

    // Architectural flags: carry/borrow, negative, zero, signed overflow.
    typedef struct packed {
        logic c;
        logic n;
        logic z;
        logic v;
    } flags_t;

    // Opcodes that take a shift amount from operand t.
    function automatic logic is_shift(input alu_op_e op);
        return op inside {LSL, LSLC, LSR, LSRC, ASR};
    endfunction

endpackage

// File: rtl/alu_seq_iter.sv
// Iterative unit: one bit per cycle for shifts, rotates-through-carry and the
// unsigned shift-add multiply. Holds the working registers and the counter.
module alu_iter_unit
    import definitions::*;
#(
    parameter int WIDTH = 8,
    parameter int SAW   = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             step,
    input  alu_op_e          op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [SAW-1:0]   cnt_init,
    input  logic             carry_in,
    output logic             last,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi,
    output logic             carry
);

    alu_op_e          op_q;
    logic [WIDTH-1:0] lo_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] mcand_q;
    logic             c_q;
    logic [SAW-1:0]   cnt_q;
    logic [WIDTH:0]   mul_sum;

    // Partial-product add for the multiplier bit currently in lo_q[0].
    always_comb begin
        // NOTE: a default is assigned before any conditional update so no latch is inferred.
        mul_sum = {1'b0, hi_q};
        if (lo_q[0]) begin
            mul_sum = mul_sum + {1'b0, mcand_q};
        end
    end

    // Load operands on acceptance, then advance one bit per step.
    // Carry always holds the last bit shifted out, so a saturated LSR leaves
    // a[WIDTH-1] in carry and a saturated LSL leaves a[0].
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: these few working registers are reset so no X can reach the result mux.
        if (!rst_n) begin
            op_q    <= ADD;
            lo_q    <= '0;
            hi_q    <= '0;
            mcand_q <= '0;
            c_q     <= 1'b0;
            cnt_q   <= '0;
        end else if (load) begin
            op_q    <= op;
            lo_q    <= (op == MUL) ? b : a;
            hi_q    <= '0;
            mcand_q <= a;
            c_q     <= carry_in;
            cnt_q   <= cnt_init;
        end else if (step) begin
            cnt_q <= cnt_q - SAW'(1);
            case (op_q)
                LSL:  {c_q, lo_q} <= {lo_q, 1'b0};
                LSLC: {c_q, lo_q} <= {lo_q, c_q};
                LSR:  {lo_q, c_q} <= {1'b0, lo_q};
                LSRC: {lo_q, c_q} <= {c_q, lo_q};
                ASR:  {lo_q, c_q} <= {lo_q[WIDTH-1], lo_q};
                MUL: begin
                    hi_q <= mul_sum[WIDTH:1];
                    lo_q <= {mul_sum[0], lo_q[WIDTH-1:1]};
                end
                default: ;
            endcase
        end
    end

    assign last  = (cnt_q == SAW'(1));
    assign lo    = lo_q;
    assign hi    = hi_q;
    assign carry = c_q;

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle ALU: FSM, single-cycle datapath and the architectural flag
// register. Iterative ops are delegated to alu_iter_unit.
module alu_seq
    import definitions::*;
#(
    parameter int WIDTH = 8,
    parameter int SAW   = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_i,
    input  alu_op_e          op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             ready_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o,
    output logic [WIDTH-1:0] result_hi_o,
    output logic             carry_o,
    output logic             neg_o,
    output logic             zero_o,
    output logic             ovf_o
);

    localparam logic [SAW-1:0] N_MAX = SAW'(WIDTH);

    alu_state_e       state_q, state_d;
    alu_op_e          op_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic             accept;
    logic [SAW-1:0]   n_raw, n_in;
    logic             iter_op_in;
    logic             iter_load, iter_last, iter_c;
    logic [WIDTH-1:0] iter_lo, iter_hi;

    flags_t           flags_q, flags_d;
    logic [WIDTH-1:0] result_q, result_d, hi_q, hi_d, value;
    logic             wr_result, cin, done_q;
    logic [WIDTH:0]   add_w, sub_w;

    assign accept     = (state_q == S_IDLE) && valid_i;
    assign n_raw      = b_i[SAW-1:0];
    assign n_in       = (n_raw > N_MAX) ? N_MAX : n_raw;
    assign iter_op_in = (is_shift(op_i) && (n_in != '0)) || (op_i == MUL);
    assign iter_load  = accept && iter_op_in;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: iterate only for shifts with n > 0 and for MUL.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (valid_i) begin
                    state_d = iter_op_in ? S_ITER : S_DONE;
                end
            end
            S_ITER: begin
                if (iter_last) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Latch opcode and operands at acceptance; inputs are ignored while busy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q <= ADD;
            a_q  <= '0;
            b_q  <= '0;
        end else if (accept) begin
            op_q <= op_i;
            a_q  <= a_i;
            b_q  <= b_i;
        end
    end

    alu_iter_unit #(
        .WIDTH (WIDTH),
        .SAW   (SAW)
    ) u_iter (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (iter_load),
        .step     (state_q == S_ITER),
        .op       (op_i),
        .a        (a_i),
        .b        (b_i),
        .cnt_init ((op_i == MUL) ? N_MAX : n_in),
        .carry_in (flags_q.c),
        .last     (iter_last),
        .lo       (iter_lo),
        .hi       (iter_hi),
        .carry    (iter_c)
    );

    // Result and flag computation, consumed on the DONE cycle.
    always_comb begin
        cin       = ((op_q == ADDC) || (op_q == SUBC)) ? flags_q.c : 1'b0;
        add_w     = {1'b0, a_q} + {1'b0, b_q} + {{WIDTH{1'b0}}, cin};
        sub_w     = {1'b0, a_q} - {1'b0, b_q} - {{WIDTH{1'b0}}, cin};
        value     = result_q;
        wr_result = 1'b1;
        hi_d      = '0;
        flags_d   = flags_q;
        case (op_q)
            ADD, ADDC: begin
                value     = add_w[WIDTH-1:0];
                flags_d.c = add_w[WIDTH];
                flags_d.v = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (add_w[WIDTH-1] != a_q[WIDTH-1]);
            end
            SUB, SUBC, CMP: begin
                // Bit WIDTH of the extended difference is the borrow.
                value     = sub_w[WIDTH-1:0];
                flags_d.c = sub_w[WIDTH];
                flags_d.v = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (sub_w[WIDTH-1] != a_q[WIDTH-1]);
                wr_result = (op_q != CMP);
            end
            AND, OR, NOT: begin
                value     = (op_q == AND) ? (a_q & b_q) :
                            (op_q == OR)  ? (a_q | b_q) : ~b_q;
                flags_d.c = 1'b0;
                flags_d.v = 1'b0;
            end
            LSL, LSLC, LSR, LSRC, ASR: begin
                // A zero shift amount passes a through and keeps the carry.
                if (b_q[SAW-1:0] == '0) begin
                    value = a_q;
                end else begin
                    value     = iter_lo;
                    flags_d.c = iter_c;
                end
            end
            MUL: begin
                value     = iter_lo;
                hi_d      = iter_hi;
                flags_d.c = |iter_hi;
                flags_d.v = 1'b0;
            end
            default: wr_result = 1'b0;
        endcase
        flags_d.z = (value == '0);
        flags_d.n = value[WIDTH-1];
        result_d  = wr_result ? value : result_q;
    end

    // Architectural outputs change only on the edge that raises done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q <= '0;
            hi_q     <= '0;
            flags_q  <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= (state_q == S_DONE);
            if (state_q == S_DONE) begin
                result_q <= result_d;
                hi_q     <= hi_d;
                flags_q  <= flags_d;
            end
        end
    end

    assign ready_o     = (state_q == S_IDLE);
    assign done_o      = done_q;
    assign result_o    = result_q;
    assign result_hi_o = hi_q;
    assign carry_o     = flags_q.c;
    assign neg_o       = flags_q.n;
    assign zero_o      = flags_q.z;
    assign ovf_o       = flags_q.v;

endmodule

// File: tb/tb_alu_seq.sv
// Directed, table-driven bench for alu_seq (WIDTH = 8) plus hand-written
// sequences for held valid, operand changes while busy and mid-op reset.
module tb_alu_seq;
    import definitions::*;

    localparam int WIDTH = 8;
    localparam int SAW   = $clog2(WIDTH) + 1;
    localparam int NV    = 22;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             valid_i = 1'b0;
    alu_op_e          op_i = ADD;
    logic [WIDTH-1:0] a_i = '0;
    logic [WIDTH-1:0] b_i = '0;
    logic             ready_o, done_o, carry_o, neg_o, zero_o, ovf_o;
    logic [WIDTH-1:0] result_o, result_hi_o;
    logic [3:0]       flags;

    int n_checks = 0;
    int n_fail   = 0;

    assign flags = {carry_o, neg_o, zero_o, ovf_o};

    alu_seq #(
        .WIDTH (WIDTH),
        .SAW   (SAW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .valid_i     (valid_i),
        .op_i        (op_i),
        .a_i         (a_i),
        .b_i         (b_i),
        .ready_o     (ready_o),
        .done_o      (done_o),
        .result_o    (result_o),
        .result_hi_o (result_hi_o),
        .carry_o     (carry_o),
        .neg_o       (neg_o),
        .zero_o      (zero_o),
        .ovf_o       (ovf_o)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    typedef struct {
        alu_op_e          op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] res;
        logic [WIDTH-1:0] hi;
        logic [3:0]       flg;   // {c, n, z, v}
        int               lat;
    } vec_t;

    vec_t vecs [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Issue one op for a single cycle, scramble inputs while busy, and return
    // the number of cycles from acceptance until done_o is seen.
    task automatic run_op(input alu_op_e op, input logic [WIDTH-1:0] a,
                          input logic [WIDTH-1:0] b, output int lat);
        int guard;
        guard = 0;
        while (!ready_o && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("ready_before_issue", 32'(ready_o), 32'd1);
        valid_i = 1'b1;
        op_i    = op;
        a_i     = a;
        b_i     = b;
        @(posedge clk);
        @(negedge clk);
        valid_i = 1'b0;
        op_i    = AND;
        a_i     = ~a;
        b_i     = ~b;
        check("busy_ready_low", 32'(ready_o), 32'd0);
        lat = 0;
        while (!done_o && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        int lat;
        int extra;

        //          op    a      b      res    hi     cnzv     lat
        vecs[0]  = '{ADD,  8'h7F, 8'h01, 8'h80, 8'h00, 4'b0101, 1};
        vecs[1]  = '{ADD,  8'hFF, 8'h01, 8'h00, 8'h00, 4'b1010, 1};
        vecs[2]  = '{ADDC, 8'h00, 8'h00, 8'h01, 8'h00, 4'b0000, 1};
        vecs[3]  = '{CMP,  8'h05, 8'h05, 8'h01, 8'h00, 4'b0010, 1};
        vecs[4]  = '{SUB,  8'h03, 8'h05, 8'hFE, 8'h00, 4'b1100, 1};
        vecs[5]  = '{SUBC, 8'h10, 8'h01, 8'h0E, 8'h00, 4'b0000, 1};
        vecs[6]  = '{SUB,  8'h80, 8'h01, 8'h7F, 8'h00, 4'b0001, 1};
        vecs[7]  = '{AND,  8'hF0, 8'h3C, 8'h30, 8'h00, 4'b0000, 1};
        vecs[8]  = '{OR,   8'h0F, 8'h80, 8'h8F, 8'h00, 4'b0100, 1};
        vecs[9]  = '{NOT,  8'h12, 8'h55, 8'hAA, 8'h00, 4'b0100, 1};
        vecs[10] = '{LSR,  8'h81, 8'h03, 8'h10, 8'h00, 4'b0000, 4};
        vecs[11] = '{ADD,  8'hFF, 8'h01, 8'h00, 8'h00, 4'b1010, 1};
        vecs[12] = '{LSL,  8'h5A, 8'h00, 8'h5A, 8'h00, 4'b1000, 1};
        vecs[13] = '{ASR,  8'h80, 8'h09, 8'hFF, 8'h00, 4'b1100, 9};
        vecs[14] = '{LSRC, 8'h02, 8'h01, 8'h81, 8'h00, 4'b0100, 2};
        vecs[15] = '{LSLC, 8'h81, 8'h01, 8'h02, 8'h00, 4'b1000, 2};
        vecs[16] = '{LSL,  8'h03, 8'h02, 8'h0C, 8'h00, 4'b0000, 3};
        vecs[17] = '{MUL,  8'hFF, 8'hFF, 8'h01, 8'hFE, 4'b1000, 9};
        vecs[18] = '{MUL,  8'h10, 8'h20, 8'h00, 8'h02, 4'b1010, 9};
        vecs[19] = '{ADD,  8'h01, 8'h02, 8'h03, 8'h00, 4'b0000, 1};
        vecs[20] = '{MUL,  8'h00, 8'h37, 8'h00, 8'h00, 4'b0010, 9};
        vecs[21] = '{LSR,  8'h18, 8'h04, 8'h01, 8'h00, 4'b1000, 5};

        // Reset state.
        #12;
        check("rst_ready", 32'(ready_o), 32'd1);
        check("rst_done", 32'(done_o), 32'd0);
        check("rst_result", 32'(result_o), 32'h0);
        check("rst_hi", 32'(result_hi_o), 32'h0);
        check("rst_flags", 32'(flags), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Table-driven vectors; flags carry from one vector to the next.
        for (int i = 0; i < NV; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat);
            check($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
            check($sformatf("v%0d_result", i), 32'(result_o), 32'(vecs[i].res));
            check($sformatf("v%0d_hi", i), 32'(result_hi_o), 32'(vecs[i].hi));
            check($sformatf("v%0d_flags", i), 32'(flags), 32'(vecs[i].flg));
            @(negedge clk);
            check($sformatf("v%0d_done_pulse", i), 32'(done_o), 32'd0);
        end

        // MUL with valid_i held high and inputs changing while busy:
        // 0x0D * 0x0B = 0x008F, result_o holds 0x01 until done.
        @(negedge clk);
        valid_i = 1'b1;
        op_i    = MUL;
        a_i     = 8'h0D;
        b_i     = 8'h0B;
        @(posedge clk);
        @(negedge clk);
        op_i = ADD;
        a_i  = 8'h77;
        b_i  = 8'h33;
        lat  = 0;
        while (!done_o && lat < 40) begin
            if (lat == 4) begin
                check("hold_result_stable", 32'(result_o), 32'h01);
                check("hold_ready_low", 32'(ready_o), 32'd0);
            end
            @(negedge clk);
            lat++;
        end
        valid_i = 1'b0;
        check("hold_latency", 32'(lat), 32'd9);
        check("hold_result", 32'(result_o), 32'h8F);
        check("hold_hi", 32'(result_hi_o), 32'h00);
        check("hold_flags", 32'(flags), 32'b0100);
        extra = 0;
        repeat (12) begin
            @(negedge clk);
            if (done_o) extra++;
        end
        check("hold_no_extra_done", 32'(extra), 32'd0);

        // Reset during iteration 4 of a MUL.
        valid_i = 1'b1;
        op_i    = MUL;
        a_i     = 8'hFF;
        b_i     = 8'hFF;
        @(posedge clk);
        @(negedge clk);
        valid_i = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_ready", 32'(ready_o), 32'd1);
        check("abort_done", 32'(done_o), 32'd0);
        check("abort_flags", 32'(flags), 32'h0);
        check("abort_result", 32'(result_o), 32'h0);
        check("abort_hi", 32'(result_hi_o), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        extra = 0;
        repeat (12) begin
            @(negedge clk);
            if (done_o) extra++;
        end
        check("abort_no_done", 32'(extra), 32'd0);

        run_op(ADD, 8'h7F, 8'h01, lat);
        check("post_rst_latency", 32'(lat), 32'd1);
        check("post_rst_result", 32'(result_o), 32'h80);
        check("post_rst_flags", 32'(flags), 32'b0101);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
